bcd_serial_add_ctrl: RTL and testbench

Digit-serial controller for multi-digit BCD addition and subtraction. It accepts two packed DIGITS-wide BCD operands through a valid/ready handshake and runs them through one shared one-digit BCD full-adder cell, least-significant digit first, one digit per clock. It returns the registered result, carry/no-borrow flag and error flag through a second valid/ready handshake. It sits between a requesting datapath (operand source) and the result consumer, and is the only user of the digit adder.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_add.sv | 26 ++
 rtl/bcd_serial_add_ctrl.sv | 131 +++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
// Holds digit width/limit, FSM state constants and per-digit helpers.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Nine's complement of one decimal digit (only meaningful for d <= 9).
  function automatic logic [BCD_DIGIT_W-1:0] nines_comp(input logic [BCD_DIGIT_W-1:0] d);
    return BCD_MAX - d;
  endfunction

  // True when the nibble is a legal decimal digit.
  function automatic logic digit_ok(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD full adder.
// Ports: a, b - BCD digits; cin - carry in; s - BCD sum digit; c - decimal carry out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] s,
  output logic                   c
);

  logic [BCD_DIGIT_W:0] t;

  // Binary sum, then +6 correction when the result leaves the decimal range.
  always_comb begin
    t = 5'(a) + 5'(b) + 5'(cin);
    s = t[BCD_DIGIT_W-1:0];
    c = 1'b0;
    if (t > 5'(BCD_MAX)) begin
      s = 4'(t + 5'd6);
      c = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add/subtract controller sharing one digit adder.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, sub operands;
// out_valid/out_ready with registered sum, cout (carry / no-borrow), err (bad digit);
// busy flags a non-idle controller.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          err,
  output logic                          busy
);

  localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic                   carry;
  logic [W-1:0]           a_r, b_r, sum_r;
  logic                   cout_r, err_r;

  logic                   accept, last, ops_ok;
  logic [W-1:0]           b_adj;
  logic [BCD_DIGIT_W-1:0] dig_a, dig_b, add_s;
  logic                   add_c;

  assign accept = in_valid && in_ready;
  assign last   = (idx == IDX_W'(DIGITS - 1));

  // Operand screening and subtrahend nine's complement on the raw inputs.
  always_comb begin
    ops_ok = 1'b1;
    b_adj  = b;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      ops_ok = ops_ok & digit_ok(a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                      & digit_ok(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
      if (sub) b_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W] = nines_comp(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

  // Select the current digit pair for the shared adder.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        dig_a = a_r[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        dig_b = b_r[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  bcd_digit_add u_digit_add (
    .a   (dig_a),
    .b   (dig_b),
    .cin (carry),
    .s   (add_s),
    .c   (add_c)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ops_ok ? RUN : DONE;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand, result, index and carry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r    <= a;
          b_r    <= b_adj;
          idx    <= '0;
          carry  <= sub;  // +1 completes the ten's complement of b
          sum_r  <= '0;
          cout_r <= 1'b0;
          err_r  <= !ops_ok;
        end
        RUN: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) sum_r[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= add_s;
          end
          carry <= add_c;
          idx   <= idx + 1'b1;
          if (last) cout_r <= add_c;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign err       = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4) against an integer model.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int          MODV   = 10000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, err, busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    logic [W-1:0] t = v;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(t[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic on the numeric operand values.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] es, output logic ec, output logic ee);
    int va, vb, tot;
    ee = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++)
      if (ma[i*4 +: 4] > 4'd9 || mb[i*4 +: 4] > 4'd9) ee = 1'b1;
    if (ee) begin
      es = '0;
      ec = 1'b0;
    end else begin
      va = bcd2int(ma);
      vb = bcd2int(mb);
      if (ms) begin
        tot = va - vb + MODV;
        ec  = (va >= vb);
      end else begin
        tot = va + vb;
        ec  = (tot >= MODV);
      end
      es = int2bcd(tot % MODV);
    end
  endtask

  // One transaction. hold = cycles out_ready stays low once out_valid is seen,
  // with in_valid held high carrying the next operands (na/nb/ns).
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic os, input int hold,
                       input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
    logic [W-1:0] es;
    logic         ec, ee;
    int           n;
    model(oa, ob, os, es, ec, ee);
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = oa; b = ob; sub = os;
    out_ready = (hold == 0);
    step();  // accept edge E0
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    // n = edges after E0 until out_valid: DIGITS for valid ops, 0 for errors
    n = 0;
    while (!out_valid && n < 50) begin
      check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      step(); n++;
    end
    check({tag, " latency"}, 32'(n), ee ? 32'd0 : 32'(DIGITS));
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " err"}, 32'(err), 32'(ee));
    if (hold > 0) begin
      in_valid = 1'b1; a = na; b = nb; sub = ns;
      for (int k = 0; k < hold; k++) begin
        step();
        check({tag, " hold valid"}, 32'(out_valid), 32'd1);
        check({tag, " hold sum"}, 32'(sum), 32'(es));
        check({tag, " hold cout"}, 32'(cout), 32'(ec));
        check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    step();  // output handshake edge
    check({tag, " post valid"}, 32'(out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    if (hold == 0) out_ready = 1'($urandom);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    step(); step();
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    check("reset release in_ready", 32'(in_ready), 32'd1);

    do_op("add1234_5678", 16'h1234, 16'h5678, 1'b0, 0, '0, '0, 1'b0);
    do_op("add9999_0001", 16'h9999, 16'h0001, 1'b0, 0, '0, '0, 1'b0);
    do_op("sub5000_1234", 16'h5000, 16'h1234, 1'b1, 0, '0, '0, 1'b0);
    do_op("sub1234_5000", 16'h1234, 16'h5000, 1'b1, 0, '0, '0, 1'b0);
    do_op("err12A4", 16'h12A4, 16'h0001, 1'b0, 0, '0, '0, 1'b0);
    // Held output; next request rides in_valid and is taken right after handshake.
    do_op("hold", 16'h0815, 16'h4711, 1'b0, 5, 16'h3333, 16'h0777, 1'b1);
    check("back2back busy", 32'(busy), 32'd0);
    do_op("next", 16'h3333, 16'h0777, 1'b1, 0, '0, '0, 1'b0);

    // Reset in the middle of RUN (idx==2 after E1, E2).
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h4321; b = 16'h1111; sub = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    check("midrun busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("midrun rst busy", 32'(busy), 32'd0);
    check("midrun rst out_valid", 32'(out_valid), 32'd0);
    check("midrun rst sum", 32'(sum), 32'd0);
    check("midrun rst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("midrun release in_ready", 32'(in_ready), 32'd1);
    step();
    check("midrun no result", 32'(out_valid), 32'd0);
    do_op("add0042_0058", 16'h0042, 16'h0058, 1'b0, 0, '0, '0, 1'b0);

    // Randomized operations, occasional bad digit and random output stalls.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
      rs = 1'($urandom);
      do_op("rand", ra, rb, rs, int'($urandom_range(0, 2)), 16'h0000, 16'h0000, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
